// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - Mini_SPI shared states and link constants
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    HOLD  = 3'd4
  } spi_state_t;

  // Shared with the receive shift register so both ends agree on mode 0, MSB first.
  localparam logic SCLK_IDLE = 1'b0;
  localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_tick_gen.sv
// rtl/spi_tick_gen.sv - sclk half-period counter with restart and one-cycle tick
module spi_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic clear,
  input  logic restart,
  output logic tick
);

  localparam int W = $clog2(DIV + 1);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  always_ff @(posedge clk) begin
    if (!clear || restart) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Held in restart while idle so the first phase of a frame is a full DIV cycles.
  assign tick = !restart && (div_cnt == LAST);

endmodule

// File: rtl/spi_tx_shifter.sv
// rtl/spi_tx_shifter.sv - Mini_SPI transmit shifter: sclk, csN and MSB-first serial data
module spi_tx_shifter
  import spi_pkg::*;
#(
  parameter int n   = 8,
  parameter int DIV = 2
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic [n-1:0] dataIn,
  output logic         busy,
  output logic         done,
  output logic         sclk,
  output logic         serialOut,
  output logic         csN
);

  localparam int BW = $clog2(n);
  localparam logic [BW-1:0] LAST_BIT = BW'(n - 1);

  spi_state_t     state, state_n;
  logic [n-1:0]   shreg, shreg_n, shifted;
  logic [BW-1:0]  bit_cnt, bit_cnt_n;
  logic           busy_n, done_n, sclk_n, sout_n, csn_n;
  logic           tick;

  spi_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .clear   (clear),
    .restart (state == IDLE),
    .tick    (tick)
  );

  assign shifted = MSB_FIRST ? {shreg[n-2:0], 1'b0} : {1'b0, shreg[n-1:1]};

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    sclk_n    = sclk;
    sout_n    = serialOut;
    csn_n     = csN;
    case (state)
      IDLE: begin
        if (start) begin
          state_n   = SETUP;
          shreg_n   = dataIn;
          bit_cnt_n = '0;
          busy_n    = 1'b1;
          csn_n     = 1'b0;
          sclk_n    = SCLK_IDLE;
          sout_n    = MSB_FIRST ? dataIn[n-1] : dataIn[0];
        end
      end
      SETUP: begin
        if (tick) begin
          state_n = HIGH;
          sclk_n  = ~SCLK_IDLE;
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_n = SCLK_IDLE;
          if (bit_cnt == LAST_BIT) begin
            state_n = HOLD;
          end else begin
            // Shift on the falling edge so the next bit settles a full half-period early.
            state_n = LOW;
            shreg_n = shifted;
            sout_n  = MSB_FIRST ? shreg[n-2] : shreg[1];
          end
        end
      end
      LOW: begin
        if (tick) begin
          state_n   = HIGH;
          sclk_n    = ~SCLK_IDLE;
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          state_n = IDLE;
          csn_n   = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= SCLK_IDLE;
      serialOut <= 1'b0;
      csN       <= 1'b1;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      sclk      <= sclk_n;
      serialOut <= sout_n;
      csN       <= csn_n;
    end
  end

endmodule
